// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key-generation datapath: the modular-inverse
// normalizer state encoding and the default word width used by the gcd stage.
package rsa_pkg;

  localparam int unsigned WORD_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StAddM,
    StSubM,
    StDone
  } modinv_state_t;

endpackage

// File: rtl/mod_adjust_unit.sv
// Combinational add/subtract of the modulus on the widened signed accumulator,
// returning the new value with its sign and "still >= m" flags.
module mod_adjust_unit
  import rsa_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
  input  logic signed [WORD_WIDTH+1:0] acc_i,
  input  logic        [WORD_WIDTH-1:0] m_i,
  input  logic                         sub_i,
  output logic signed [WORD_WIDTH+1:0] acc_o,
  output logic                         neg_o,
  output logic                         ge_m_o
);

  // Two guard bits keep acc +/- m from ever wrapping.
  logic signed [WORD_WIDTH+1:0] m_ext;

  assign m_ext  = {2'b00, m_i};
  assign acc_o  = sub_i ? (acc_i - m_ext) : (acc_i + m_ext);
  assign neg_o  = acc_o[WORD_WIDTH+1];
  assign ge_m_o = (acc_o >= m_ext);

endmodule

// File: rtl/mod_inv_normalize.sv
// Reduces a signed Bezout coefficient into [0, m) by repeated add/subtract of m.
// Define MODINV_ITER_LIMIT_EN to abort with iter_err after MAX_ITER adjustments.
module mod_inv_normalize
  import rsa_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEFAULT,
  parameter int unsigned MAX_ITER   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] gcd_in,
  input  logic [WORD_WIDTH-1:0] coeff_in,
  input  logic [WORD_WIDTH-1:0] modulus,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] inv_out,
  output logic                  no_inverse,
  output logic                  iter_err
);

`ifdef MODINV_ITER_LIMIT_EN
  localparam bit LimitEn = 1'b1;
`else
  localparam bit LimitEn = 1'b0;
`endif

  modinv_state_t state_q, state_d;
  logic signed [WORD_WIDTH+1:0] acc_q, acc_d, adj_acc, m_ext;
  logic [WORD_WIDTH-1:0] m_q, m_d, gcd_q, gcd_d, inv_q, inv_d;
  logic [31:0] cnt_q, cnt_d;
  logic noinv_flag_q, noinv_flag_d, err_flag_q, err_flag_d;
  logic done_q, done_d, no_inv_q, no_inv_d, iter_err_q, iter_err_d;
  logic adj_neg, adj_ge, adj_exit;

  assign m_ext = {2'b00, m_q};

  mod_adjust_unit #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_adjust (
    .acc_i (acc_q),
    .m_i   (m_q),
    .sub_i (state_q == StSubM),
    .acc_o (adj_acc),
    .neg_o (adj_neg),
    .ge_m_o(adj_ge)
  );

  assign adj_exit = (state_q == StAddM) ? !adj_neg : !adj_ge;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    m_d          = m_q;
    gcd_d        = gcd_q;
    cnt_d        = cnt_q;
    noinv_flag_d = noinv_flag_q;
    err_flag_d   = err_flag_q;
    done_d       = 1'b0;
    inv_d        = inv_q;
    no_inv_d     = no_inv_q;
    iter_err_d   = iter_err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d        = {{2{coeff_in[WORD_WIDTH-1]}}, coeff_in};
          m_d          = modulus;
          gcd_d        = gcd_in;
          cnt_d        = '0;
          noinv_flag_d = 1'b0;
          err_flag_d   = 1'b0;
          state_d      = StCheck;
        end
      end
      StCheck: begin
        if (m_q == '0 || gcd_q != WORD_WIDTH'(1)) begin
          noinv_flag_d = 1'b1;
          acc_d        = '0;
          state_d      = StDone;
        end else if (acc_q[WORD_WIDTH+1]) begin
          state_d = StAddM;
        end else if (acc_q >= m_ext) begin
          state_d = StSubM;
        end else begin
          state_d = StDone;
        end
      end
      StAddM, StSubM: begin
        acc_d = adj_acc;
        cnt_d = cnt_q + 32'd1;
        if (adj_exit) begin
          state_d = StDone;
        end else if (LimitEn && cnt_d == MAX_ITER) begin
          err_flag_d = 1'b1;
          acc_d      = '0;
          state_d    = StDone;
        end
      end
      StDone: begin
        done_d     = 1'b1;
        inv_d      = acc_q[WORD_WIDTH-1:0];
        no_inv_d   = noinv_flag_q;
        iter_err_d = err_flag_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      m_q          <= '0;
      gcd_q        <= '0;
      cnt_q        <= '0;
      noinv_flag_q <= 1'b0;
      err_flag_q   <= 1'b0;
      done_q       <= 1'b0;
      inv_q        <= '0;
      no_inv_q     <= 1'b0;
      iter_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      m_q          <= m_d;
      gcd_q        <= gcd_d;
      cnt_q        <= cnt_d;
      noinv_flag_q <= noinv_flag_d;
      err_flag_q   <= err_flag_d;
      done_q       <= done_d;
      inv_q        <= inv_d;
      no_inv_q     <= no_inv_d;
      iter_err_q   <= iter_err_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign inv_out    = inv_q;
  assign no_inverse = no_inv_q;
  assign iter_err   = iter_err_q;

endmodule
